ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32I pipeline. It is the consumer end of the ID/EX pipeline register.
- Takes the registered decode bundle and computes the ALU result, resolves branches and jumps, and drives the PC redirect back to IF.
- Owns the squash sequencer that kills the two younger wrong-path instructions after a redirect.
- Registers its results into the EX/MEM pipeline register.

---
 rtl/ex_stage.sv | 186 ++++++++++++++++++
 tb/tb_ex_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RV32I pipeline: ALU, branch/jump resolution, PC redirect,
// the squash sequencer that kills wrong-path instructions, and the EX/MEM pipeline register.
module ex_stage #(
    parameter int XLEN         = 32,
    parameter int SQUASH_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] i_RS1E,
    input  logic [XLEN-1:0] i_RS2E,
    input  logic [XLEN-1:0] i_ImmE,
    input  logic [6:0]      i_OpE,
    input  logic [2:0]      i_Func3E,
    input  logic [3:0]      i_ALUCtrlE,
    input  logic [XLEN-1:0] i_PcE,
    input  logic [4:0]      i_RdE,
    input  logic            i_BranchE,
    input  logic            i_JalE,
    input  logic            i_JalrE,
    input  logic            i_Selop1E,
    input  logic            i_Selop2E,
    input  logic            i_WrenE,
    input  logic [1:0]      i_ResultsrcE,
    input  logic            i_RegSrc,
    output logic            o_PcSrcE,
    output logic [XLEN-1:0] o_PcTargetE,
    output logic [XLEN-1:0] o_ALUResultM,
    output logic [XLEN-1:0] o_WriteDataM,
    output logic [XLEN-1:0] o_PcPlus4M,
    output logic [4:0]      o_RdM,
    output logic [2:0]      o_Func3M,
    output logic            o_WrenM,
    output logic [1:0]      o_ResultsrcM,
    output logic            o_RegWrM,
    output logic            o_ValidM
);

    localparam int CNT_W = (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_LD = CNT_W'(SQUASH_DEPTH);

    typedef enum logic {
        RUN,
        SQUASH
    } squash_state_e;

    squash_state_e   state_q;
    logic [CNT_W-1:0] cnt_q;

    logic            squashNow;
    logic            branchCond;
    logic            take;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [4:0]      shamt;
    logic [XLEN-1:0] jalrSum;

    logic [XLEN-1:0] aluResult_d, aluResult_q;
    logic [XLEN-1:0] writeData_d, writeData_q;
    logic [XLEN-1:0] pcPlus4_d,   pcPlus4_q;
    logic [4:0]      rd_d,        rd_q;
    logic [2:0]      func3_d,     func3_q;
    logic            wren_d,      wren_q;
    logic [1:0]      resultSrc_d, resultSrc_q;
    logic            regWr_d,     regWr_q;
    logic            valid_d,     valid_q;

    // The opcode is fully decoded upstream into the control bits above.
    logic unusedOpcode;
    assign unusedOpcode = ^i_OpE;

    assign opA   = i_Selop1E ? i_PcE : i_RS1E;
    assign opB   = i_Selop2E ? i_ImmE : i_RS2E;
    assign shamt = opB[4:0];

    always_comb begin
        aluResult_d = '0;
        case (i_ALUCtrlE)
            4'b0000: aluResult_d = opA + opB;
            4'b0001: aluResult_d = opA - opB;
            4'b0010: aluResult_d = opA << shamt;
            4'b0011: aluResult_d = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
            4'b0100: aluResult_d = {{(XLEN-1){1'b0}}, (opA < opB)};
            4'b0101: aluResult_d = opA ^ opB;
            4'b0110: aluResult_d = opA >> shamt;
            4'b0111: aluResult_d = $unsigned($signed(opA) >>> shamt);
            4'b1000: aluResult_d = opA | opB;
            4'b1001: aluResult_d = opA & opB;
            4'b1010: aluResult_d = opB;
            default: aluResult_d = '0;
        endcase
    end

    // Branch conditions always compare the raw register operands, never the ALU inputs.
    always_comb begin
        branchCond = 1'b0;
        case (i_Func3E)
            3'b000:  branchCond = (i_RS1E == i_RS2E);
            3'b001:  branchCond = (i_RS1E != i_RS2E);
            3'b100:  branchCond = ($signed(i_RS1E) < $signed(i_RS2E));
            3'b101:  branchCond = ($signed(i_RS1E) >= $signed(i_RS2E));
            3'b110:  branchCond = (i_RS1E < i_RS2E);
            3'b111:  branchCond = (i_RS1E >= i_RS2E);
            default: branchCond = 1'b0;
        endcase
    end

    assign take      = (i_BranchE & branchCond) | i_JalE | i_JalrE;
    assign squashNow = (state_q == SQUASH);
    assign jalrSum   = i_RS1E + i_ImmE;

    assign o_PcSrcE    = take & ~squashNow & ~rst;
    assign o_PcTargetE = i_JalrE ? {jalrSum[XLEN-1:1], 1'b0} : (i_PcE + i_ImmE);

    // Squash sequencer: a redirect from a live instruction kills the next SQUASH_DEPTH ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (take && (SQUASH_DEPTH > 0)) begin
                        state_q <= SQUASH;
                        cnt_q   <= DEPTH_LD;
                    end
                end
                SQUASH: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign writeData_d = i_RS2E;
    assign pcPlus4_d   = i_PcE + XLEN'(4);
    assign rd_d        = i_RdE;
    assign func3_d     = i_Func3E;
    assign resultSrc_d = i_ResultsrcE;
    assign wren_d      = i_WrenE & ~squashNow;
    assign regWr_d     = i_RegSrc & ~squashNow & (i_RdE != 5'd0);
    assign valid_d     = ~squashNow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluResult_q <= '0;
            writeData_q <= '0;
            pcPlus4_q   <= '0;
            rd_q        <= '0;
            func3_q     <= '0;
            wren_q      <= 1'b0;
            resultSrc_q <= '0;
            regWr_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            aluResult_q <= aluResult_d;
            writeData_q <= writeData_d;
            pcPlus4_q   <= pcPlus4_d;
            rd_q        <= rd_d;
            func3_q     <= func3_d;
            wren_q      <= wren_d;
            resultSrc_q <= resultSrc_d;
            regWr_q     <= regWr_d;
            valid_q     <= valid_d;
        end
    end

    assign o_ALUResultM = aluResult_q;
    assign o_WriteDataM = writeData_q;
    assign o_PcPlus4M   = pcPlus4_q;
    assign o_RdM        = rd_q;
    assign o_Func3M     = func3_q;
    assign o_WrenM      = wren_q;
    assign o_ResultsrcM = resultSrc_q;
    assign o_RegWrM     = regWr_q;
    assign o_ValidM     = valid_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by random instructions,
// all checked against an arithmetic reference model of the execute stage.
module tb_ex_stage;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        sel1;
        logic        sel2;
        logic        wren;
        logic [1:0]  rsrc;
        logic        regSrc;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rs1E, rs2E, immE, pcE;
    logic [6:0]  opE;
    logic [2:0]  func3E;
    logic [3:0]  aluCtrlE;
    logic [4:0]  rdE;
    logic        branchE, jalE, jalrE, selop1E, selop2E, wrenE, regSrcE;
    logic [1:0]  resultSrcE;

    logic        pcSrcE;
    logic [31:0] pcTargetE, aluResultM, writeDataM, pcPlus4M;
    logic [4:0]  rdM;
    logic [2:0]  func3M;
    logic        wrenM, regWrM, validM;
    logic [1:0]  resultSrcM;

    int checks = 0;
    int errors = 0;
    int killLeft = 0;

    ex_stage #(.XLEN(32), .SQUASH_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .i_RS1E(rs1E), .i_RS2E(rs2E), .i_ImmE(immE), .i_OpE(opE),
        .i_Func3E(func3E), .i_ALUCtrlE(aluCtrlE), .i_PcE(pcE), .i_RdE(rdE),
        .i_BranchE(branchE), .i_JalE(jalE), .i_JalrE(jalrE),
        .i_Selop1E(selop1E), .i_Selop2E(selop2E), .i_WrenE(wrenE),
        .i_ResultsrcE(resultSrcE), .i_RegSrc(regSrcE),
        .o_PcSrcE(pcSrcE), .o_PcTargetE(pcTargetE), .o_ALUResultM(aluResultM),
        .o_WriteDataM(writeDataM), .o_PcPlus4M(pcPlus4M), .o_RdM(rdM),
        .o_Func3M(func3M), .o_WrenM(wrenM), .o_ResultsrcM(resultSrcM),
        .o_RegWrM(regWrM), .o_ValidM(validM)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        int sh;
        longint sa, sb;
        logic [31:0] fill;
        sh = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (op)
            4'd0:    return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'd1:    return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            4'd2:    return 32'((64'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
            4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:    return (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return 32'(64'(a) / (64'd1 << sh));
            4'd7:    return 32'(64'(a) / (64'd1 << sh)) | fill;
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic refTake(input stim_t s);
        longint sa, sb;
        logic cond;
        sa = longint'($signed(s.rs1));
        sb = longint'($signed(s.rs2));
        case (s.f3)
            3'd0:    cond = (s.rs1 == s.rs2);
            3'd1:    cond = (s.rs1 != s.rs2);
            3'd4:    cond = (sa < sb);
            3'd5:    cond = (sa >= sb);
            3'd6:    cond = (64'(s.rs1) < 64'(s.rs2));
            3'd7:    cond = (64'(s.rs1) >= 64'(s.rs2));
            default: cond = 1'b0;
        endcase
        return (s.br && cond) || s.jal || s.jalr;
    endfunction

    function automatic logic [31:0] refTarget(input stim_t s);
        logic [31:0] sum;
        if (s.jalr) begin
            sum = s.rs1 + s.imm;
            return sum - 32'(sum % 2);
        end
        return s.pc + s.imm;
    endfunction

    function automatic stim_t makeNop();
        stim_t s;
        s = '{rs1: 32'd0, rs2: 32'd0, imm: 32'd0, op: 7'h13, f3: 3'd0, alu: 4'd0,
              pc: 32'h0, rd: 5'd1, br: 1'b0, jal: 1'b0, jalr: 1'b0, sel1: 1'b0,
              sel2: 1'b1, wren: 1'b0, rsrc: 2'd0, regSrc: 1'b1};
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic driveInputs(input stim_t s);
        rs1E = s.rs1; rs2E = s.rs2; immE = s.imm; opE = s.op; func3E = s.f3;
        aluCtrlE = s.alu; pcE = s.pc; rdE = s.rd; branchE = s.br; jalE = s.jal;
        jalrE = s.jalr; selop1E = s.sel1; selop2E = s.sel2; wrenE = s.wren;
        resultSrcE = s.rsrc; regSrcE = s.regSrc;
    endtask

    // One instruction in EX: check the redirect, clock it, check EX/MEM, advance the model.
    task automatic applyStimulus(input stim_t s, input string name);
        logic squashed, taken;
        logic [31:0] a, b;
        driveInputs(s);
        #1;
        squashed = (killLeft > 0);
        taken    = refTake(s);
        a = s.sel1 ? s.pc : s.rs1;
        b = s.sel2 ? s.imm : s.rs2;
        checkOutput({name, ".pcsrc"}, 32'(pcSrcE), 32'(taken && !squashed));
        checkOutput({name, ".target"}, pcTargetE, refTarget(s));
        @(posedge clk);
        #1;
        checkOutput({name, ".alu"}, aluResultM, refAlu(s.alu, a, b));
        checkOutput({name, ".wdata"}, writeDataM, s.rs2);
        checkOutput({name, ".pc4"}, pcPlus4M, s.pc + 32'd4);
        checkOutput({name, ".rd"}, 32'(rdM), 32'(s.rd));
        checkOutput({name, ".f3"}, 32'(func3M), 32'(s.f3));
        checkOutput({name, ".wren"}, 32'(wrenM), 32'(s.wren && !squashed));
        checkOutput({name, ".rsrc"}, 32'(resultSrcM), 32'(s.rsrc));
        checkOutput({name, ".regwr"}, 32'(regWrM), 32'(s.regSrc && !squashed && s.rd != 0));
        checkOutput({name, ".valid"}, 32'(validM), 32'(!squashed));
        if (squashed) killLeft--;
        else if (taken) killLeft = 2;
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, ".alu"}, aluResultM, 32'd0);
        checkOutput({name, ".wdata"}, writeDataM, 32'd0);
        checkOutput({name, ".pc4"}, pcPlus4M, 32'd0);
        checkOutput({name, ".rd"}, 32'(rdM), 32'd0);
        checkOutput({name, ".f3"}, 32'(func3M), 32'd0);
        checkOutput({name, ".wren"}, 32'(wrenM), 32'd0);
        checkOutput({name, ".rsrc"}, 32'(resultSrcM), 32'd0);
        checkOutput({name, ".regwr"}, 32'(regWrM), 32'd0);
        checkOutput({name, ".valid"}, 32'(validM), 32'd0);
        checkOutput({name, ".pcsrc"}, 32'(pcSrcE), 32'd0);
    endtask

    initial begin
        stim_t s;
        rst = 1'b1;
        s = makeNop();
        s.jal = 1'b1;
        driveInputs(s);
        #2;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;
        killLeft = 0;

        s = makeNop();
        s.rs1 = 32'h7FFF_FFFF; s.imm = 32'd1; s.alu = 4'd0;
        applyStimulus(s, "add");
        checkOutput("add.literal", aluResultM, 32'h8000_0000);

        s = makeNop();
        s.rs1 = 32'h8000_0000; s.rs2 = 32'h24; s.sel2 = 1'b0; s.alu = 4'd7;
        applyStimulus(s, "sra");
        checkOutput("sra.literal", aluResultM, 32'hF800_0000);

        s = makeNop();
        s.rs1 = 32'd1; s.rs2 = 32'hFFFF_FFFF; s.sel2 = 1'b0; s.alu = 4'd4;
        applyStimulus(s, "sltu");
        checkOutput("sltu.literal", aluResultM, 32'd1);

        s = makeNop();
        s.rs1 = 32'hFFFF_FFFF; s.rs2 = 32'd1; s.pc = 32'h100; s.imm = 32'h20;
        s.br = 1'b1; s.f3 = 3'd4; s.regSrc = 1'b0; s.op = 7'h63;
        applyStimulus(s, "blt");
        checkOutput("blt.literal", pcTargetE, 32'h120);

        for (int i = 0; i < 2; i++) begin
            s = makeNop();
            s.op = 7'h23; s.wren = 1'b1; s.regSrc = 1'b1; s.rd = 5'd7;
            s.f3 = 3'd2; s.rs2 = 32'hCAFE_0000 + 32'(i);
            applyStimulus(s, "sw_squashed");
        end
        checkOutput("sw.squash_literal", 32'(validM), 32'd0);

        s = makeNop();
        s.rs1 = 32'd5; s.imm = 32'd6;
        applyStimulus(s, "post_squash");
        checkOutput("post_squash.literal", 32'(validM), 32'd1);

        s = makeNop();
        s.rs1 = 32'h1003; s.imm = 32'd4; s.rd = 5'd1; s.jalr = 1'b1;
        s.pc = 32'h400; s.rsrc = 2'd2; s.op = 7'h67;
        applyStimulus(s, "jalr");
        checkOutput("jalr.literal", pcTargetE, 32'h1006);

        s = makeNop();
        s.jal = 1'b1; s.pc = 32'h404; s.imm = 32'h80; s.rd = 5'd1; s.op = 7'h6F;
        applyStimulus(s, "jal_in_window");
        applyStimulus(makeNop(), "filler");

        s = makeNop();
        s.rd = 5'd0; s.regSrc = 1'b1; s.rs1 = 32'd9; s.imm = 32'd1;
        applyStimulus(s, "rd0");

        // Taken BEQ then a reset pulse in the middle of its squash window.
        s = makeNop();
        s.br = 1'b1; s.f3 = 3'd0; s.rs1 = 32'd3; s.rs2 = 32'd3; s.pc = 32'h200;
        s.imm = 32'h10; s.regSrc = 1'b0;
        applyStimulus(s, "beq");
        s.rs1 = 32'hABCD; s.rs2 = 32'hABCD; s.wren = 1'b1; s.regSrc = 1'b1;
        driveInputs(s);
        #1;
        checkOutput("beq_squash.pcsrc", 32'(pcSrcE), 32'd0);
        rst = 1'b1;
        #1;
        checkAllZero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        killLeft = 0;
        s = makeNop();
        s.rs1 = 32'd40; s.imm = 32'd2;
        applyStimulus(s, "after_rst");
        checkOutput("after_rst.literal", 32'(validM), 32'd1);

        // Random instruction mix checked against the model.
        for (int i = 0; i < 300; i++) begin
            int kind;
            s = makeNop();
            s.rs1  = $urandom();
            s.rs2  = ($urandom_range(0, 3) == 0) ? s.rs1 : $urandom();
            s.imm  = $urandom();
            s.pc   = {$urandom_range(0, 65535), 2'b00};
            s.alu  = 4'($urandom_range(0, 15));
            s.f3   = 3'($urandom_range(0, 7));
            s.rd   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            s.sel1 = 1'($urandom_range(0, 1));
            s.sel2 = 1'($urandom_range(0, 1));
            s.wren = 1'($urandom_range(0, 1));
            s.rsrc = 2'($urandom_range(0, 3));
            s.regSrc = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 7));
            s.jal  = (kind == 0);
            s.jalr = (kind == 1);
            s.br   = (kind == 2) || (kind == 3);
            applyStimulus(s, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
